// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
//
// Serial stimulus transmitter. A parallel pattern is shifted out MSB-first on
// the 1-bit line `x`, one bit per clock. The whole pattern can be sent several
// times back to back, with a single idle (x_valid=0) cycle between copies.
// The FSM state is exported on `S` so sequence recognizers and benches can
// follow the transmitter cycle by cycle.
//
// Ports
//   CLK       in   system clock, rising edge active
//   RESET     in   synchronous active-low reset
//   start     in   transmit request, only looked at in IDLE
//   pattern   in   [WIDTH-1:0] bits to send (MSB first), captured in LOAD
//   repeat_n  in   [CNT_W-1:0] number of copies, captured in LOAD (0 means 1)
//   x         out  serial data bit (0 whenever x_valid is low)
//   x_valid   out  x carries a pattern bit
//   busy      out  high in every state except IDLE
//   done      out  single-cycle pulse after the last copy
//   S         out  [2:0] current state encoding
//
// All outputs are a pure decode of registers; no input reaches an output
// without passing through a flop first.
// -----------------------------------------------------------------------------
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       S
);

  localparam int BC_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_LOAD  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_GAP   = 3'b011,
    ST_DONE  = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;   // bits still to send, MSB is on the line
  logic [WIDTH-1:0] saved_q, saved_d;   // copy of the pattern for later repeats
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] reps_q, reps_d;     // copies left, including the current one

  logic last_bit;
  assign last_bit = (bit_cnt_q == BC_W'(WIDTH - 1));

  // NOTE: every always_comb output gets a default before the case statement so
  // no path leaves a signal unassigned and a latch can never be inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    saved_d   = saved_q;
    bit_cnt_d = bit_cnt_q;
    reps_d    = reps_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        saved_d   = pattern;
        shift_d   = pattern;
        reps_d    = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        if (last_bit) begin
          // reps_q counts down to 1, so the full 2^CNT_W-1 range never wraps.
          if (reps_q > CNT_W'(1)) begin
            reps_d  = reps_q - CNT_W'(1);
            state_d = ST_GAP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_GAP: begin
        shift_d   = saved_q;
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      // Encodings 101..111 are unreachable; recover to IDLE if ever seen.
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      saved_q   <= '0;
      bit_cnt_q <= '0;
      reps_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      saved_q   <= saved_d;
      bit_cnt_q <= bit_cnt_d;
      reps_q    <= reps_d;
    end
  end

  assign S       = state_q;
  assign x_valid = (state_q == ST_SHIFT);
  assign x       = x_valid & shift_q[WIDTH-1];
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial stimulus transmitter: shifts a parallel bit pattern out MSB-first on a 1-bit serial line `x`, one bit per clock.
- It is the transmit end of the serial-bit interface consumed by the team's sequence-recognizer FSMs.
- Supports a programmable repeat count with a one-cycle gap between repeats.
- Exposes its state on `S`, as the recognizers do, for debug and bench checking.

Parameters:
- WIDTH, 8, number of pattern bits shifted per repeat (>=2).
- CNT_W, 4, width of the repeat-count input.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- start  input  1  request to transmit; sampled only in IDLE.
- pattern  input  WIDTH  bits to send, MSB first; captured in LOAD.
- repeat_n  input  CNT_W  number of repeats; captured in LOAD; 0 is treated as 1.
- x  output  1  serial data bit.
- x_valid  output  1  high while `x` carries a pattern bit.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of the final repeat.
- S  output  3  current state encoding.

Behaviour:
- Reset: RESET low at a rising edge forces on the next cycle:
  - state IDLE, S=3'b000;
  - x=0, x_valid=0, busy=0, done=0;
  - shift register, bit counter and repeat counter cleared.
- Reset wins over every other input. Reset mid-transfer aborts immediately: no further bits are sent and done is not pulsed.
- States:
  - IDLE=000: start=1 at an edge -> LOAD. Otherwise stay in IDLE.
  - LOAD=001: capture `pattern` into a saved register and into the shift register. Capture reps = (repeat_n==0 ? 1 : repeat_n). Bit counter = 0. Next state SHIFT. x_valid=0.
  - SHIFT=010:
    - x = shift register MSB; x_valid=1.
    - Each edge: shift left by 1, bit counter +1.
    - After the WIDTH-th bit: if reps>1 -> GAP and reps -1; else -> DONE.
  - GAP=011: x=0, x_valid=0 for exactly one cycle. Reload the shift register from the saved pattern, bit counter = 0. Next state SHIFT.
  - DONE=100: done=1 and busy=1 for this cycle only; x=0, x_valid=0. Next state IDLE.
  - Encodings 101..111 are unreachable; if entered, go to IDLE on the next edge.
- x=0 whenever x_valid=0.
- `x`, `x_valid`, `busy`, `done` and `S` are decoded from registered state only; there is no combinational path from the inputs.
- Timing, with start sampled high at edge 0:
  - LOAD during cycle 1;
  - first bit valid during cycle 2;
  - DONE during cycle 2 + R*WIDTH + (R-1), where R is the effective repeat count;
  - IDLE on the cycle after DONE.
- `start` is ignored outside IDLE.
- `start` held high through DONE re-triggers: IDLE lasts one cycle, then LOAD.
- Changes to `pattern` or `repeat_n` after LOAD do not affect the transfer in progress; the saved copies are used for every repeat.
- Repeat counter width is CNT_W. The maximum of 2^CNT_W - 1 repeats is sent without wrap.

Test Plan:
- Reset: RESET=0 for 2 cycles with start=1 -> S=000, x=0, x_valid=0, busy=0, done=0 throughout; no LOAD entered.
- Single send: pattern=8'b1011_0010, repeat_n=1, 1-cycle start pulse -> x sequence 1,0,1,1,0,0,1,0 with x_valid=1 for 8 cycles (cycles 2..9); done=1 in cycle 10 with S=100; S=000 in cycle 11.
- Repeat with gap: pattern=8'hA5, repeat_n=3 -> three copies of 10100101, each separated by one x_valid=0 cycle with S=011; done in cycle 28.
- repeat_n=0: pattern=8'hFF -> behaves exactly as repeat_n=1, done in cycle 10.
- Input stability: pattern changed to 8'h00 and start pulsed again during SHIFT -> output bits unchanged (original pattern); no second transfer queued.
- Reset mid-operation: RESET=0 at the 4th SHIFT edge -> next cycle S=000, x_valid=0; done never asserts; a fresh start then produces a full, correct transfer.
